// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch-side, data-side and memory-side
// handshake signals of the unified memory port arbiter, plus its stall and
// error outputs. The "slave" modport is the arbiter's view. The "master"
// modport is the view of the surrounding pipeline and memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Fetch stage
    logic              IReq;
    logic [ADDR_W-1:0] IAddr;
    logic [DATA_W-1:0] IRdata;
    logic              IDone;
    logic              FetchKill;
    // Memory stage
    logic              DReq;
    logic              DWe;
    logic [ADDR_W-1:0] DAddr;
    logic [DATA_W-1:0] DWdata;
    logic [DATA_W-1:0] DRdata;
    logic              DDone;
    // Memory port
    logic              MReq;
    logic              MWe;
    logic [ADDR_W-1:0] MAddr;
    logic [DATA_W-1:0] MWdata;
    logic [DATA_W-1:0] MRdata;
    logic              MReady;
    // Pipeline control
    logic              StallFetch;
    logic              StallAll;
    logic              MemErr;

    modport slave (
        input  IReq, IAddr, FetchKill, DReq, DWe, DAddr, DWdata, MRdata, MReady,
        output IRdata, IDone, DRdata, DDone, MReq, MWe, MAddr, MWdata,
               StallFetch, StallAll, MemErr
    );

    modport master (
        output IReq, IAddr, FetchKill, DReq, DWe, DAddr, DWdata, MRdata, MReady,
        input  IRdata, IDone, DRdata, DDone, MReq, MWe, MAddr, MWdata,
               StallFetch, StallAll, MemErr
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one unified memory port between instruction
// fetch and the memory stage. Data accesses win unless the previous grant
// was data, so both requesters alternate under contention. A fetch made
// stale by a redirect (FetchKill) completes silently and is re-issued.
// Stall outputs cover the multi-cycle access.
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort a transfer after
// TIMEOUT cycles without MReady. The abort raises a sticky MemErr and
// returns a NOP for a fetch or zero for a load.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_IFETCH,
        S_DACC,
        S_IDONE,
        S_DDONE
    } state_t;

    localparam logic [DATA_W-1:0] NOP_INSN = DATA_W'(32'h0000_0013);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_port_arbiter: TIMEOUT must be at least 1");
    end

    state_t            state_q;
    logic              mreq_q;
    logic              mwe_q;
    logic [ADDR_W-1:0] maddr_q;
    logic [DATA_W-1:0] mwdata_q;
    logic [DATA_W-1:0] irdata_q;
    logic [DATA_W-1:0] drdata_q;
    logic              idone_q;
    logic              ddone_q;
    logic              last_d_q;
    logic              kill_q;

    // A transfer ends on MReady or on timeout. The end also selects the
    // value returned to the requester.
    logic              xfer_end;
    logic              timeout_hit;
    logic [DATA_W-1:0] fetch_rdata;
    logic [DATA_W-1:0] load_rdata;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             mem_err_q;
`endif

    // End-of-transfer detection and the data returned to the requester
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        timeout_hit = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        timeout_hit = !bus.MReady && (cnt_q == CNT_W'(TIMEOUT - 1));
`endif
        xfer_end    = bus.MReady || timeout_hit;
        fetch_rdata = bus.MReady ? bus.MRdata : NOP_INSN;
        load_rdata  = bus.MReady ? bus.MRdata : '0;
    end

    // Arbitration FSM with registered memory-port and completion outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mreq_q   <= 1'b0;
            mwe_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
            idone_q  <= 1'b0;
            ddone_q  <= 1'b0;
            last_d_q <= 1'b0;
            kill_q   <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments, so every register here samples pre-edge values.
            case (state_q)
                S_IDLE: begin
                    // A redirect seen here also covers a fetch granted in this same cycle.
                    kill_q <= kill_q | bus.FetchKill;
                    if (bus.DReq && !(bus.IReq && last_d_q)) begin
                        mreq_q   <= 1'b1;
                        mwe_q    <= bus.DWe;
                        maddr_q  <= bus.DAddr;
                        mwdata_q <= bus.DWdata;
                        state_q  <= S_DACC;
`ifdef MEM_ARB_TIMEOUT_EN
                        cnt_q    <= '0;
`endif
                    end else if (bus.IReq) begin
                        mreq_q   <= 1'b1;
                        mwe_q    <= 1'b0;
                        maddr_q  <= bus.IAddr;
                        mwdata_q <= '0;
                        last_d_q <= 1'b0;
                        state_q  <= S_IFETCH;
`ifdef MEM_ARB_TIMEOUT_EN
                        cnt_q    <= '0;
`endif
                    end
                end
                S_IFETCH: begin
                    if (xfer_end) begin
                        mreq_q <= 1'b0;
                        if (kill_q || bus.FetchKill) begin
                            // Stale fetch: drop the data and go back to re-issue at the new PC.
                            kill_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            irdata_q <= fetch_rdata;
                            idone_q  <= 1'b1;
                            state_q  <= S_IDONE;
                        end
`ifdef MEM_ARB_TIMEOUT_EN
                        mem_err_q <= mem_err_q | timeout_hit;
`endif
                    end else begin
                        kill_q <= kill_q | bus.FetchKill;
`ifdef MEM_ARB_TIMEOUT_EN
                        cnt_q  <= cnt_q + 1'b1;
`endif
                    end
                end
                S_DACC: begin
                    if (xfer_end) begin
                        mreq_q   <= 1'b0;
                        drdata_q <= load_rdata;
                        ddone_q  <= 1'b1;
                        last_d_q <= 1'b1;
                        state_q  <= S_DDONE;
`ifdef MEM_ARB_TIMEOUT_EN
                        mem_err_q <= mem_err_q | timeout_hit;
`endif
                    end else begin
`ifdef MEM_ARB_TIMEOUT_EN
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end
                S_IDONE: begin
                    idone_q <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_DDONE: begin
                    ddone_q <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.MReq   = mreq_q;
    assign bus.MWe    = mwe_q;
    assign bus.MAddr  = maddr_q;
    assign bus.MWdata = mwdata_q;
    assign bus.IRdata = irdata_q;
    assign bus.DRdata = drdata_q;
    assign bus.IDone  = idone_q;
    assign bus.DDone  = ddone_q;

    // Stalls are combinational so that they release in the Done cycle itself.
    assign bus.StallFetch = bus.IReq & ~idone_q;
    assign bus.StallAll   = bus.DReq & ~ddone_q;

`ifdef MEM_ARB_TIMEOUT_EN
    assign bus.MemErr = mem_err_q;
`else
    assign bus.MemErr = 1'b0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: applies a table of per-cycle vectors for loads and
// for fetch/data alternation. Hand-written sequences then cover a delayed
// store, a killed fetch, reset during a data access and, when
// MEM_ARB_TIMEOUT_EN is defined, the timeout path.
// Inputs are driven on the falling edge. Outputs are sampled 1 time unit
// later, well away from the rising edge.
module tb_mem_port_arbiter;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so a broken design can never hang the run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic [31:0] daddr;
        logic        mready;
        logic [31:0] mrdata;
        logic        e_mreq;
        logic [31:0] e_maddr;
        logic        e_idone;
        logic        e_ddone;
        logic [31:0] e_rdata;
        logic        e_sf;
        logic        e_sa;
    } vec_t;

    localparam int N_VEC = 17;
    vec_t vecs [N_VEC];

    function automatic vec_t mk(
        input logic ireq, input logic [31:0] iaddr,
        input logic dreq, input logic [31:0] daddr,
        input logic mready, input logic [31:0] mrdata,
        input logic e_mreq, input logic [31:0] e_maddr,
        input logic e_idone, input logic e_ddone, input logic [31:0] e_rdata,
        input logic e_sf, input logic e_sa);
        vec_t v;
        v.ireq = ireq;     v.iaddr = iaddr;   v.dreq = dreq;       v.daddr = daddr;
        v.mready = mready; v.mrdata = mrdata; v.e_mreq = e_mreq;   v.e_maddr = e_maddr;
        v.e_idone = e_idone; v.e_ddone = e_ddone; v.e_rdata = e_rdata;
        v.e_sf = e_sf;     v.e_sa = e_sa;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ireq, input logic [31:0] iaddr, input logic kill,
                         input logic dreq, input logic dwe, input logic [31:0] daddr,
                         input logic [31:0] dwdata, input logic mready, input logic [31:0] mrdata);
        bus.IReq      = ireq;
        bus.IAddr     = iaddr;
        bus.FetchKill = kill;
        bus.DReq      = dreq;
        bus.DWe       = dwe;
        bus.DAddr     = daddr;
        bus.DWdata    = dwdata;
        bus.MReady    = mready;
        bus.MRdata    = mrdata;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Cycle table: the load with MReady always high, then D/I alternation
        //            ireq iaddr      dreq daddr    rdy mrdata         mreq maddr     idn ddn rdata          sf sa
        vecs[0]  = mk(0, 32'h0,    1, 32'h40, 1, 32'hFFFF_0000, 0, 32'h0,     0, 0, 32'h0,          0, 1);
        vecs[1]  = mk(0, 32'h0,    1, 32'h40, 1, 32'h1111_2222, 1, 32'h40,    0, 0, 32'h0,          0, 1);
        vecs[2]  = mk(0, 32'h0,    1, 32'h40, 1, 32'hFFFF_0001, 0, 32'h0,     0, 1, 32'h1111_2222,  0, 0);
        vecs[3]  = mk(0, 32'h0,    0, 32'h0,  1, 32'h0,         0, 32'h0,     0, 0, 32'h0,          0, 0);
        vecs[4]  = mk(1, 32'h100,  1, 32'h80, 1, 32'h0,         0, 32'h0,     0, 0, 32'h0,          1, 1);
        vecs[5]  = mk(1, 32'h100,  1, 32'h80, 1, 32'hAAAA_0001, 1, 32'h100,   0, 0, 32'h0,          1, 1);
        vecs[6]  = mk(1, 32'h100,  1, 32'h80, 1, 32'h0,         0, 32'h0,     1, 0, 32'hAAAA_0001,  0, 1);
        vecs[7]  = mk(1, 32'h104,  1, 32'h80, 1, 32'h0,         0, 32'h0,     0, 0, 32'h0,          1, 1);
        vecs[8]  = mk(1, 32'h104,  1, 32'h80, 1, 32'hBBBB_0002, 1, 32'h80,    0, 0, 32'h0,          1, 1);
        vecs[9]  = mk(1, 32'h104,  1, 32'h80, 1, 32'h0,         0, 32'h0,     0, 1, 32'hBBBB_0002,  1, 0);
        vecs[10] = mk(1, 32'h104,  1, 32'h84, 1, 32'h0,         0, 32'h0,     0, 0, 32'h0,          1, 1);
        vecs[11] = mk(1, 32'h104,  1, 32'h84, 1, 32'hCCCC_0003, 1, 32'h104,   0, 0, 32'h0,          1, 1);
        vecs[12] = mk(1, 32'h104,  1, 32'h84, 1, 32'h0,         0, 32'h0,     1, 0, 32'hCCCC_0003,  0, 1);
        vecs[13] = mk(0, 32'h0,    1, 32'h84, 1, 32'h0,         0, 32'h0,     0, 0, 32'h0,          0, 1);
        vecs[14] = mk(0, 32'h0,    1, 32'h84, 1, 32'hDDDD_0004, 1, 32'h84,    0, 0, 32'h0,          0, 1);
        vecs[15] = mk(0, 32'h0,    1, 32'h84, 1, 32'h0,         0, 32'h0,     0, 1, 32'hDDDD_0004,  0, 0);
        vecs[16] = mk(0, 32'h0,    0, 32'h0,  0, 32'h0,         0, 32'h0,     0, 0, 32'h0,          0, 0);

        // Reset state, with requests applied while reset is held
        @(negedge clk);
        drive(1, 32'h10, 0, 1, 0, 32'h20, 0, 1, 32'h55);
        #1;
        check("rst_stall_fetch", bus.StallFetch, 1);
        check("rst_stall_all",   bus.StallAll,   1);
        check("rst_mreq",        bus.MReq,       0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        #1;
        check("rst_maddr",  bus.MAddr,  0);
        check("rst_mwe",    bus.MWe,    0);
        check("rst_mwdata", bus.MWdata, 0);
        check("rst_irdata", bus.IRdata, 0);
        check("rst_drdata", bus.DRdata, 0);
        check("rst_idone",  bus.IDone,  0);
        check("rst_ddone",  bus.DDone,  0);
        check("rst_memerr", bus.MemErr, 0);

        for (int i = 0; i < N_VEC; i++) begin
            @(negedge clk);
            drive(vecs[i].ireq, vecs[i].iaddr, 0, vecs[i].dreq, 0, vecs[i].daddr, 0,
                  vecs[i].mready, vecs[i].mrdata);
            #1;
            check($sformatf("v%0d_mreq", i),  bus.MReq,  vecs[i].e_mreq);
            if (vecs[i].e_mreq) begin
                check($sformatf("v%0d_maddr", i), bus.MAddr, vecs[i].e_maddr);
                check($sformatf("v%0d_mwe", i),   bus.MWe,   0);
            end
            check($sformatf("v%0d_idone", i), bus.IDone, vecs[i].e_idone);
            check($sformatf("v%0d_ddone", i), bus.DDone, vecs[i].e_ddone);
            if (vecs[i].e_idone) check($sformatf("v%0d_irdata", i), bus.IRdata, vecs[i].e_rdata);
            if (vecs[i].e_ddone) check($sformatf("v%0d_drdata", i), bus.DRdata, vecs[i].e_rdata);
            check($sformatf("v%0d_stall_fetch", i), bus.StallFetch, vecs[i].e_sf);
            check($sformatf("v%0d_stall_all", i),   bus.StallAll,   vecs[i].e_sa);
        end

        // Store with MReady held low for 3 cycles, with DWdata changing after the grant
        @(negedge clk);
        drive(0, 0, 0, 1, 1, 32'h90, 32'hDEAD_BEEF, 0, 0);
        #1;
        check("st_grant_mreq", bus.MReq, 0);
        for (int w = 1; w <= 3; w++) begin
            @(negedge clk);
            drive(0, 0, 0, 1, 1, 32'h90, 32'h1234_5678, 0, 32'hFFFF_FFFF);
            #1;
            check($sformatf("st_w%0d_mreq", w),   bus.MReq,   1);
            check($sformatf("st_w%0d_mwe", w),    bus.MWe,    1);
            check($sformatf("st_w%0d_maddr", w),  bus.MAddr,  32'h90);
            check($sformatf("st_w%0d_mwdata", w), bus.MWdata, 32'hDEAD_BEEF);
            check($sformatf("st_w%0d_ddone", w),  bus.DDone,  0);
            check($sformatf("st_w%0d_stall", w),  bus.StallAll, 1);
        end
        @(negedge clk);
        drive(0, 0, 0, 1, 1, 32'h90, 32'h1234_5678, 1, 0);
        #1;
        check("st_ready_mwdata", bus.MWdata, 32'hDEAD_BEEF);
        @(negedge clk);
        drive(0, 0, 0, 1, 1, 32'h90, 32'h1234_5678, 0, 0);
        #1;
        check("st_ddone", bus.DDone,    1);
        check("st_mreq",  bus.MReq,     0);
        check("st_stall", bus.StallAll, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("st_idle_ddone", bus.DDone, 0);

        // Killed fetch: 4 wait cycles, FetchKill in the second, then a re-issue at the new PC
        @(negedge clk);
        drive(1, 32'h200, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("kf_stall", bus.StallFetch, 1);
        @(negedge clk);
        #1;
        check("kf_w1_mreq",  bus.MReq,  1);
        check("kf_w1_maddr", bus.MAddr, 32'h200);
        check("kf_w1_mwe",   bus.MWe,   0);
        @(negedge clk);
        drive(1, 32'h200, 1, 0, 0, 0, 0, 0, 0);
        #1;
        check("kf_w2_mreq", bus.MReq, 1);
        @(negedge clk);
        drive(1, 32'h300, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("kf_w3_maddr", bus.MAddr, 32'h200);
        @(negedge clk);
        #1;
        check("kf_w4_mreq", bus.MReq, 1);
        @(negedge clk);
        drive(1, 32'h300, 0, 0, 0, 0, 0, 1, 32'h0BAD_0BAD);
        #1;
        check("kf_stale_mreq", bus.MReq, 1);
        @(negedge clk);
        drive(1, 32'h300, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("kf_no_idone", bus.IDone,      0);
        check("kf_idle_mreq", bus.MReq,      0);
        check("kf_stall_on", bus.StallFetch, 1);
        @(negedge clk);
        drive(1, 32'h300, 0, 0, 0, 0, 0, 1, 32'h0050_0093);
        #1;
        check("kf_reissue_mreq",  bus.MReq,  1);
        check("kf_reissue_maddr", bus.MAddr, 32'h300);
        @(negedge clk);
        drive(1, 32'h300, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("kf_idone",  bus.IDone,      1);
        check("kf_irdata", bus.IRdata,     32'h0050_0093);
        check("kf_stall_off", bus.StallFetch, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("kf_end_idone", bus.IDone, 0);

        // Reset asserted during a data access
        @(negedge clk);
        drive(0, 0, 0, 1, 1, 32'h60, 32'h7777_8888, 0, 0);
        @(negedge clk);
        #1;
        check("ra_mreq_before", bus.MReq, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ra_mreq",   bus.MReq,     0);
        check("ra_mwe",    bus.MWe,      0);
        check("ra_maddr",  bus.MAddr,    0);
        check("ra_mwdata", bus.MWdata,   0);
        check("ra_ddone",  bus.DDone,    0);
        check("ra_stall",  bus.StallAll, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        rst_n = 1'b1;
        #1;
        check("ra_rel_stall", bus.StallAll, 0);
        @(negedge clk);
        drive(0, 0, 0, 1, 0, 32'h64, 0, 1, 32'h0A0B_0C0D);
        #1;
        check("ra_idle_mreq",  bus.MReq,  0);
        check("ra_idle_ddone", bus.DDone, 0);
        @(negedge clk);
        #1;
        check("ra_new_mreq",  bus.MReq,  1);
        check("ra_new_maddr", bus.MAddr, 32'h64);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("ra_new_ddone",  bus.DDone,  1);
        check("ra_new_drdata", bus.DRdata, 32'h0A0B_0C0D);

`ifdef MEM_ARB_TIMEOUT_EN
        // Fetch with MReady stuck low: abort after 15 wait cycles with a NOP
        @(negedge clk);
        drive(1, 32'h400, 0, 0, 0, 0, 0, 0, 0);
        for (int w = 1; w <= 15; w++) begin
            @(negedge clk);
            #1;
            check($sformatf("to_w%0d_mreq", w), bus.MReq, 1);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("to_mreq",   bus.MReq,   0);
        check("to_idone",  bus.IDone,  1);
        check("to_irdata", bus.IRdata, 32'h0000_0013);
        check("to_memerr", bus.MemErr, 1);
        repeat (3) @(negedge clk);
        #1;
        check("to_memerr_held", bus.MemErr, 1);
        check("to_idle_idone",  bus.IDone,  0);
`else
        check("memerr_tied", bus.MemErr, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single unified instruction/data memory port between the fetch stage (F) and the memory stage (M) of the 5-stage pipelined core, and generates the pipeline stalls that cover the multi-cycle accesses. It sits beside the hazard unit: its stall outputs are ORed into the pipeline-register enables on top of the load-use stall. It also discards a fetch made stale by a taken branch or jump.

## Interface
- ADDR_W, 32, memory address width
- DATA_W, 32, memory data width
- TIMEOUT, 15, maximum wait cycles for MReady (used only with MEM_ARB_TIMEOUT_EN)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- IReq  in  1  fetch request (F stage)
- IAddr  in  ADDR_W  fetch address (PCF)
- IRdata  out  DATA_W  fetched instruction, valid while IDone=1
- IDone  out  1  one-cycle fetch completion pulse
- FetchKill  in  1  redirect (PCSrcE): discard the in-flight fetch
- DReq  in  1  data request (M stage)
- DWe  in  1  1=store, 0=load
- DAddr  in  ADDR_W  data address
- DWdata  in  DATA_W  store data
- DRdata  out  DATA_W  load data, valid while DDone=1
- DDone  out  1  one-cycle data completion pulse
- MReq, MWe  out  1  memory request / write enable
- MAddr  out  ADDR_W, MWdata  out  DATA_W  memory address / write data
- MRdata  in  DATA_W  memory read data, valid when MReady=1
- MReady  in  1  memory completes the transfer this cycle
- StallFetch  out  1  freeze PC and the IF/ID register
- StallAll  out  1  freeze every pipeline register
- MemErr  out  1  sticky timeout error flag

## Operation
- States: IDLE, IFETCH, DACC, IDONE, DDONE.
- New requests are sampled only in IDLE.
  - Priority: DReq wins over IReq, except when the `lastD` flag is set. `lastD` is set on entering DDONE and cleared when a fetch is granted. So with both requests pending, data and fetch alternate.
  - On grant, MAddr/MWdata/MWe are registered from the winning requester, MReq=1 next cycle. A fetch always has MWe=0.
- IFETCH/DACC: hold MReq and the registered address/data stable until MReady=1. On MReady: capture MRdata into IRdata/DRdata, drop MReq, go to IDONE/DDONE.
- IDONE/DDONE: IDone/DDone=1 for exactly this cycle, then go to IDLE. A request still high in this cycle is not a new request.
- An in-flight transfer is never pre-empted.
- FetchKill in IDLE, IFETCH, or the grant cycle: sets a `kill` flag.
  - When that fetch completes, IDONE is skipped: IDone stays 0, go straight to IDLE, `kill` is cleared, and the fetch is re-issued with the new IAddr.
  - FetchKill during IDONE has no effect; the hazard unit's FlushD handles that instruction.
- StallFetch = IReq & ~IDone (combinational).
- StallAll = DReq & ~DDone (combinational).
- Reset: state IDLE; MReq, MWe, MAddr, MWdata, IRdata, DRdata, IDone, DDone, MemErr, lastD, kill and the wait counter all 0. Stalls follow the inputs during reset.
- Reset asserted mid-transfer abandons the transfer immediately: MReq=0 with no Done pulse.

## Timing
- Minimum access: request seen in IDLE at cycle 0, MReq=1 in cycle 1. If MReady=1 in cycle 1, Done=1 in cycle 2. That is 3 cycles per access and 2 stall cycles.
- Each cycle of MReady=0 adds one cycle.
- Back-to-back: after Done in cycle n, the next grant is sampled in IDLE in cycle n+1 and MReq=1 in cycle n+2.
- MRdata is sampled only on the rising edge where MReq=1 and MReady=1.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A wait counter increments each IFETCH/DACC cycle with MReady=0.
  - When it reaches TIMEOUT: drop MReq, set MemErr (cleared only by reset), and complete normally via IDONE/DDONE.
  - The completion returns 32'h00000013 (NOP) for a fetch and 0 for a load.
  - The counter clears on every grant.
- `MEM_ARB_TIMEOUT_EN` undefined: the arbiter waits forever, MemErr is tied to 0, and there is no counter.

## Test plan
- Load, MReady always 1: DReq=1 and DAddr=0x40 at cycle 0 -> MReq=1, MAddr=0x40 in cycle 1; DDone=1 with DRdata=MRdata in cycle 2; StallAll=1 in cycles 0–1, 0 in cycle 2.
- IReq and DReq both high in IDLE, lastD=0 -> data granted first, then fetch. Repeat with both held -> grants alternate D, I, D, I.
- Fetch with MReady low for 4 cycles, FetchKill pulsed in the second wait cycle -> no IDone; a new MReq with the updated IAddr issues 2 cycles after the stale MReady.
- Store, DWe=1, DWdata=0xDEADBEEF, MReady delayed 3 cycles -> MWe=1 and MWdata stable through all wait cycles; DDone one cycle after MReady.
- rst_n low while in DACC -> MReq=0 asynchronously, all outputs at reset values, state IDLE after release.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT=15, MReady stuck 0 on a fetch -> MReq drops after 15 wait cycles, IDone=1 with IRdata=0x00000013, MemErr=1 held.
